skid_pipeline_reg: RTL and testbench
====================================

SKID_PIPELINE_REG -- requirements
Module: skid_pipeline_reg

Interface
REQ-001 Parameter DATA_W, default 32: payload width in bits; legal range 1..256.
REQ-002 Parameter CNT_W, default 16: width of the stall-cycle counter; legal range 1..32.
REQ-003 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1: reset; synchronous, active-high.
REQ-005 Port flush  input  1: synchronous pipeline flush, e.g. on branch mispredict.
REQ-006 Port in_valid  input  1: upstream presents a payload.
REQ-007 Port in_ready  output  1: block can accept a payload this cycle.
REQ-008 Port in_data  input  DATA_W: upstream payload.
REQ-009 Port out_valid  output  1: out_data holds a valid payload.
REQ-010 Port out_ready  input  1: downstream accepts the payload this cycle.
REQ-011 Port out_data  output  DATA_W: payload to downstream.
REQ-012 Port occupancy  output  2: number of stored payloads, 0..2.
REQ-013 Port stall_cnt  output  CNT_W: saturating count of back-pressure cycles.

Function
REQ-014 Transfer-in SHALL occur at a rising edge when in_valid && in_ready; transfer-out SHALL occur at a rising edge when out_valid && out_ready.
REQ-015 Storage SHALL be two DATA_W registers: main, which drives out_data, and skid.
REQ-016 The FSM SHALL have three states: EMPTY (occupancy 0), FULL (1), SKID (2); occupancy SHALL be a registered encoding of the state.
REQ-017 out_valid SHALL be 1 in FULL and SKID and 0 in EMPTY; in_ready SHALL be 1 in EMPTY and FULL and 0 in SKID.
REQ-018 in_ready and out_valid SHALL be decoded from registers only, with no combinational path from in_valid or out_ready.
REQ-019 Transitions from EMPTY:
- transfer-in: main<=in_data, go to FULL;
- otherwise stay in EMPTY.
REQ-020 Transitions from FULL:
- transfer-in and transfer-out together: main<=in_data, stay in FULL;
- transfer-in only: skid<=in_data, go to SKID;
- transfer-out only: go to EMPTY;
- neither: hold.
REQ-021 Transitions from SKID:
- transfer-out: main<=skid, go to FULL;
- otherwise hold; no input is possible because in_ready=0.
REQ-022 Latency SHALL be 1 cycle: a payload accepted at edge N appears on out_data with out_valid=1 after edge N, provided the block was EMPTY or draining.
REQ-023 Ordering SHALL be strict FIFO; no payload SHALL be dropped or duplicated except by flush.
REQ-024 out_data SHALL remain stable while out_valid && !out_ready.
REQ-025 Flush behaviour:
- flush=1 at an edge SHALL force EMPTY, overriding any transfer that cycle;
- an in_data presented that cycle SHALL be discarded;
- main and skid contents SHALL be left unchanged;
- stall_cnt SHALL be left unchanged.
REQ-026 stall_cnt SHALL increment by 1 on each edge where out_valid && !out_ready and flush=0, and SHALL saturate at 2^CNT_W-1 without wrap.
REQ-027 Payload bits SHALL pass through unmodified; there is no width conversion.

Reset
REQ-028 With rst=1 at an edge the block SHALL enter EMPTY and set:
- out_valid=0, in_ready=1, occupancy=0;
- out_data=0 and skid=0;
- stall_cnt=0.
REQ-029 rst SHALL take priority over flush and over all transfers; a mid-transfer payload SHALL be discarded.
REQ-030 In the first cycle after rst deasserts, the block SHALL accept input with in_ready=1.

Verification
REQ-031 Streaming: out_ready=1, in_valid=1 for 4 cycles with data 0x11,0x22,0x33,0x44 -> the same sequence on out_data, 1-cycle latency, occupancy stays 1, stall_cnt=0.
REQ-032 Back-pressure: FULL holding 0xA5, out_ready=0, input 0x5A accepted -> occupancy=2, in_ready=0; then out_ready=1 for 2 cycles -> out_data 0xA5 then 0x5A, ending EMPTY.
REQ-033 Flush: SKID state with flush=1 and in_valid=1 (0x77) -> next cycle out_valid=0, occupancy=0, in_ready=1; 0x77 never appears at the output.
REQ-034 Saturation: CNT_W=3, out_valid=1, out_ready=0 for 10 cycles -> stall_cnt goes 1..7 and holds at 7.
REQ-035 Reset mid-operation: occupancy=2, stall_cnt=5, rst=1 for one edge -> all outputs reach the REQ-028 values; with in_valid=1 on the next cycle, the payload is accepted.
REQ-036 Random: random in_valid/out_ready at 50% for 10k cycles against a scoreboard -> order preserved, no loss, out_data stable under stall, and in_ready/out_valid match the occupancy decode.

Source files
------------

// File: rtl/skid_pipeline_reg.sv
// Two-entry skid buffer between a valid/ready producer and consumer.
// Handshake outputs are decoded from the state register, so no ready/valid path is combinational.
module skid_pipeline_reg #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] FULL  = 2'd1;
    localparam logic [1:0] SKID  = 2'd2;

    logic [1:0]        state;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic [CNT_W-1:0]  stall_q;
    logic              xfer_in;
    logic              xfer_out;

    assign in_ready  = (state != SKID);
    assign out_valid = (state != EMPTY);
    assign occupancy = state;
    assign out_data  = main_q;
    assign stall_cnt = stall_q;

    assign xfer_in  = in_valid && in_ready;
    assign xfer_out = out_valid && out_ready;

    // Flush only empties the state; stored payloads stay in the registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (xfer_in) begin
                        main_q <= in_data;
                        state  <= FULL;
                    end
                end
                FULL: begin
                    if (xfer_in && xfer_out) begin
                        main_q <= in_data;
                    end else if (xfer_in) begin
                        skid_q <= in_data;
                        state  <= SKID;
                    end else if (xfer_out) begin
                        state <= EMPTY;
                    end
                end
                SKID: begin
                    if (xfer_out) begin
                        main_q <= skid_q;
                        state  <= FULL;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    // Counts cycles where downstream holds off a valid payload; saturates at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (!flush && out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_skid_pipeline_reg.sv
// Scoreboard bench for skid_pipeline_reg: a payload queue models storage and order,
// and a separate counter models the saturating stall count.
module tb_skid_pipeline_reg;

    localparam int DATA_W  = 32;
    localparam int CNT_W   = 3;
    localparam int CNT_MAX = 7;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cnt;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] sb[$];
    int                stall_m = 0;

    skid_pipeline_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Advance one edge and update the reference model from the inputs driven for it.
    task automatic step();
        bit fi;
        bit fo;
        bit st;
        logic [DATA_W-1:0] d;
        fi = in_valid && (sb.size() < 2);
        fo = (sb.size() > 0) && out_ready;
        st = (sb.size() > 0) && !out_ready;
        d  = in_data;
        @(posedge clk);
        if (rst) begin
            sb.delete();
            stall_m = 0;
        end else if (flush) begin
            sb.delete();
        end else begin
            if (st && stall_m < CNT_MAX) stall_m++;
            if (fo) void'(sb.pop_front());
            if (fi) sb.push_back(d);
        end
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %0b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %0b expected 1", in_ready); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("[TB] FAIL reset_occupancy: got %0d expected 0", occupancy); end
        checks++; if (out_data !== '0) begin errors++; $display("[TB] FAIL reset_out_data: got %0h expected 0", out_data); end
        checks++; if (stall_cnt !== '0) begin errors++; $display("[TB] FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
    endtask

    task automatic test_streaming();
        logic [DATA_W-1:0] pat [4];
        pat[0] = 32'h11; pat[1] = 32'h22; pat[2] = 32'h33; pat[3] = 32'h44;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = pat[i];
            step();
            checks++; if (out_valid !== 1'b1 || out_data !== pat[i]) begin errors++; $display("[TB] FAIL stream_data[%0d]: got v=%0b d=%0h expected v=1 d=%0h", i, out_valid, out_data, pat[i]); end
            checks++; if (occupancy !== 2'd1) begin errors++; $display("[TB] FAIL stream_occupancy[%0d]: got %0d expected 1", i, occupancy); end
            checks++; if (stall_cnt !== '0) begin errors++; $display("[TB] FAIL stream_stall_cnt[%0d]: got %0d expected 0", i, stall_cnt); end
        end
        in_valid = 1'b0;
        step();
        checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stream_drain: got occ=%0d v=%0b expected occ=0 v=0", occupancy, out_valid); end
    endtask

    task automatic test_backpressure();
        do_reset();
        in_valid = 1'b1; in_data = 32'hA5; out_ready = 1'b0;
        step();
        in_data = 32'h5A;
        step();
        checks++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_skid_state: got occ=%0d rdy=%0b expected occ=2 rdy=0", occupancy, in_ready); end
        checks++; if (out_data !== 32'hA5 || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_first_out: got v=%0b d=%0h expected v=1 d=a5", out_valid, out_data); end
        checks++; if (stall_cnt !== 3'd1) begin errors++; $display("[TB] FAIL bp_stall_cnt: got %0d expected 1", stall_cnt); end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        checks++; if (out_data !== 32'h5A || occupancy !== 2'd1) begin errors++; $display("[TB] FAIL bp_second_out: got d=%0h occ=%0d expected d=5a occ=1", out_data, occupancy); end
        step();
        checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_empty: got occ=%0d v=%0b rdy=%0b expected 0 0 1", occupancy, out_valid, in_ready); end
    endtask

    task automatic test_flush();
        do_reset();
        in_valid = 1'b1; in_data = 32'h01; out_ready = 1'b0;
        step();
        in_data = 32'h02;
        step();
        flush = 1'b1; in_data = 32'h77;
        step();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_state: got v=%0b occ=%0d rdy=%0b expected 0 0 1", out_valid, occupancy, in_ready); end
        checks++; if (out_data !== 32'h01) begin errors++; $display("[TB] FAIL flush_main_kept: got %0h expected 1", out_data); end
        checks++; if (stall_cnt !== 3'd1) begin errors++; $display("[TB] FAIL flush_stall_kept: got %0d expected 1", stall_cnt); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_no_ghost[%0d]: got v=%0b d=%0h expected v=0", i, out_valid, out_data); end
        end
        in_valid = 1'b1; in_data = 32'h88;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h88) begin errors++; $display("[TB] FAIL flush_recover: got v=%0b d=%0h expected v=1 d=88", out_valid, out_data); end
    endtask

    task automatic test_saturation();
        int exp_cnt;
        do_reset();
        in_valid = 1'b1; in_data = 32'h3C;
        step();
        in_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            exp_cnt = (k < CNT_MAX) ? k : CNT_MAX;
            checks++; if (stall_cnt !== CNT_W'(exp_cnt)) begin errors++; $display("[TB] FAIL sat_count[%0d]: got %0d expected %0d", k, stall_cnt, exp_cnt); end
        end
        checks++; if (out_data !== 32'h3C) begin errors++; $display("[TB] FAIL sat_data_stable: got %0h expected 3c", out_data); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        in_valid = 1'b1; in_data = 32'hAA;
        step();
        in_data = 32'hBB;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        checks++; if (occupancy !== 2'd2 || stall_cnt !== 3'd5) begin errors++; $display("[TB] FAIL mid_setup: got occ=%0d cnt=%0d expected occ=2 cnt=5", occupancy, stall_cnt); end
        rst = 1'b1; flush = 1'b1; in_valid = 1'b1; in_data = 32'h99; out_ready = 1'b1;
        step();
        rst = 1'b0; flush = 1'b0; out_ready = 1'b0; in_data = 32'hC3;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0) begin errors++; $display("[TB] FAIL mid_reset_ctrl: got v=%0b rdy=%0b occ=%0d expected 0 1 0", out_valid, in_ready, occupancy); end
        checks++; if (out_data !== '0 || stall_cnt !== '0) begin errors++; $display("[TB] FAIL mid_reset_regs: got d=%0h cnt=%0d expected 0 0", out_data, stall_cnt); end
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== 32'hC3) begin errors++; $display("[TB] FAIL mid_accept: got v=%0b d=%0h expected v=1 d=c3", out_valid, out_data); end
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] prev_data;
        bit                prev_stall;
        do_reset();
        prev_stall = 1'b0;
        prev_data  = '0;
        for (int c = 0; c < 10000; c++) begin
            in_valid  = 1'($urandom_range(1));
            out_ready = 1'($urandom_range(1));
            flush     = ($urandom_range(127) == 0);
            in_data   = $urandom;
            checks++; if (occupancy !== 2'(sb.size())) begin errors++; $display("[TB] FAIL rnd_occupancy@%0d: got %0d expected %0d", c, occupancy, sb.size()); end
            checks++; if (out_valid !== (sb.size() > 0) || in_ready !== (sb.size() < 2)) begin errors++; $display("[TB] FAIL rnd_handshake@%0d: got v=%0b rdy=%0b for occ=%0d", c, out_valid, in_ready, sb.size()); end
            if (sb.size() > 0) begin
                checks++; if (out_data !== sb[0]) begin errors++; $display("[TB] FAIL rnd_order@%0d: got %0h expected %0h", c, out_data, sb[0]); end
            end
            if (prev_stall) begin
                checks++; if (out_data !== prev_data) begin errors++; $display("[TB] FAIL rnd_stable@%0d: got %0h expected %0h", c, out_data, prev_data); end
            end
            checks++; if (stall_cnt !== CNT_W'(stall_m)) begin errors++; $display("[TB] FAIL rnd_stall_cnt@%0d: got %0d expected %0d", c, stall_cnt, stall_m); end
            prev_stall = (sb.size() > 0) && !out_ready && !flush;
            prev_data  = out_data;
            step();
        end
        idle_inputs();
    endtask

    initial begin
        $display("[TB] starting skid_pipeline_reg bench");
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
